// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// RAW-hazard tracker that sits beside the decode stage of the pipelined WISC
// core. Each architectural register has a small down-counter. The counter
// holds the number of cycles left until the in-flight result for that register
// can be used. The decode stage is stalled while any source operand it reads
// is still counting.
//
// Every issuing producer loads its own latency, so ALU, load and multi-cycle
// producers all use the same counters. The counter is loaded with
// issue_lat + EARLY_PEN:
//   - a normal (EX-stage) consumer waits while the count is above EARLY_PEN.
//   - an early (decode-stage) consumer, such as a branch, JR or JALR, waits
//     until the count reaches zero.
//
// Parameters
//   REG_W      register address width; NREG = 2**REG_W tracked registers
//   LAT_W      width of issue_lat; producer latency range 0..2**LAT_W-1
//   EARLY_PEN  extra wait of an early consumer beyond a normal consumer
//   PERF_W     width of the saturating stall performance counter
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   issue_valid        decode instruction advances into EX this cycle
//   issue_wr           advancing instruction writes a register
//   issue_dst          destination register of the advancing instruction
//   issue_lat          cycles after entering EX until the result is forwardable
//   rs_addr, rt_addr   source registers of the instruction in decode
//   rs_used, rt_used   the corresponding source is actually read
//   early              decode instruction consumes its operands in decode
//   freeze             global pipeline hold; scoreboard state is frozen
//   kill               flush; clears every pending entry
//   stall              combinational decode stall
//   busy               per-register pending flag (count != 0)
//   stall_cycles       saturating count of cycles with stall=1 and freeze=0
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_W     = 3,
  parameter int LAT_W     = 2,
  parameter int EARLY_PEN = 1,
  parameter int PERF_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic [REG_W-1:0]      issue_dst,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic [REG_W-1:0]      rs_addr,
  input  logic [REG_W-1:0]      rt_addr,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic                  early,
  input  logic                  freeze,
  input  logic                  kill,
  output logic                  stall,
  output logic [2**REG_W-1:0]   busy,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int NREG    = 2 ** REG_W;
  localparam int CNT_W   = LAT_W + 1;
  localparam int CNT_MAX = (2 ** CNT_W) - 1;
  localparam int LAT_MAX = (2 ** LAT_W) - 1;

  // The largest value ever loaded is LAT_MAX + EARLY_PEN. It must fit in a
  // counter, otherwise it would wrap and release consumers too early.
  if (EARLY_PEN < 0 || LAT_MAX + EARLY_PEN > CNT_MAX) begin : g_bad_early_pen
    $error("hazard_scoreboard: EARLY_PEN=%0d does not fit in %0d-bit counters",
           EARLY_PEN, CNT_W);
  end

  localparam logic [CNT_W-1:0] PEN = CNT_W'(EARLY_PEN);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] stall_cycles_d;

  // ---------------------------------------------------------------------------
  // Hazard detection
  //
  // This logic uses only the registered counts and the decode-side inputs. No
  // issue_* signal reaches stall, so stall cannot form a combinational loop
  // through the issue qualification below.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hz_thresh;
  logic             hz_rs;
  logic             hz_rt;

  always_comb begin
    hz_thresh = early ? '0 : PEN;
    hz_rs     = cnt_q[rs_addr] > hz_thresh;
    hz_rt     = cnt_q[rt_addr] > hz_thresh;
    // If rs_addr == rt_addr, both terms read the same entry. OR-ing the two
    // terms gives the same result as evaluating that register once.
    stall     = (rs_used & hz_rs) | (rt_used & hz_rt);
  end

  // ---------------------------------------------------------------------------
  // Counter next state
  //
  // An instruction held in decode by a stall has not really issued. Masking
  // with stall therefore keeps a stalled writer from reloading its destination
  // every cycle that it waits.
  // ---------------------------------------------------------------------------
  logic iss;

  always_comb begin
    iss = issue_valid & issue_wr & ~stall & ~freeze & ~kill;
    for (int r = 0; r < NREG; r++) begin
      // NOTE: every always_comb output gets a default first; a path that
      // skips the assignment would otherwise infer a latch.
      cnt_d[r] = cnt_q[r];
      if (kill) begin
        cnt_d[r] = '0;
      end else if (!freeze) begin
        if (iss && issue_dst == REG_W'(r)) begin
          // A reload takes priority over the decrement of the same entry. A
          // new latency that is shorter than the remaining count also wins.
          cnt_d[r] = CNT_W'(issue_lat) + PEN;
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall performance counter. It counts only the cycles in which the stall
  // really costs a decode slot (not frozen), and it saturates at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !freeze && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is live control state, not data storage, so
      // every entry is reset; stale counts would stall decode after reset.
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge values regardless of statement order.
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW-hazard unit for the pipelined WISC core, sitting beside the decode stage. It keeps a per-register countdown of cycles until each in-flight result becomes usable, and asserts a decode stall when a source operand is not yet available. Producer latency is supplied per instruction, so load, multi-cycle and ALU producers share one mechanism. Early consumers such as branches and JR, which need the operand in decode, stall longer.

## Interface
Parameters:
- REG_W, 3: register address width; NREG = 2**REG_W entries.
- LAT_W, 2: width of issue_lat; producer latency range is 0..2**LAT_W-1.
- EARLY_PEN, 1: extra cycles an early (decode-stage) consumer waits beyond a normal consumer.
- PERF_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  the decode instruction advances into EX this cycle.
- issue_wr  in  1  the advancing instruction writes a register.
- issue_dst  in  REG_W  destination register of the advancing instruction.
- issue_lat  in  LAT_W  cycles after entering EX before the result is forwardable to EX: 0 for ALU, 1 for load.
- rs_addr, rt_addr  in  REG_W  source registers of the instruction in decode.
- rs_used, rt_used  in  1  the corresponding source is read.
- early  in  1  the decode instruction consumes its operands in decode (branch, JR, JALR).
- freeze  in  1  global pipeline hold (memory stall); the scoreboard holds its state.
- kill  in  1  clears the scoreboard (halt/exception flush).
- stall  out  1  combinational decode stall.
- busy  out  NREG  per-register flag, cnt[r] != 0.
- stall_cycles  out  PERF_W  saturating count of cycles with stall=1 and freeze=0.

## Operation
- State: cnt[0..NREG-1], each CNT_W = LAT_W+1 bits wide, sized to hold 2**LAT_W-1+EARLY_PEN. Elaboration fails if EARLY_PEN does not fit in CNT_W.
- Effective issue: iss = issue_valid & issue_wr & ~stall & ~freeze & ~kill.
- Per-register update, in priority order:
  - kill: cnt[r] <= 0.
  - freeze: cnt[r] holds.
  - iss and r == issue_dst: cnt[r] <= issue_lat + EARLY_PEN. Issue overrides the decrement of the same register.
  - otherwise, if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
- Source hazard: hz(a) = cnt[a] > (early ? 0 : EARLY_PEN).
- stall = (rs_used & hz(rs_addr)) | (rt_used & hz(rt_addr)).
  - stall is purely a function of registered state and the current decode inputs, with no path from the issue_* ports.
  - stall is not masked by freeze.
- Resulting waits with defaults (EARLY_PEN = 1):
  - ALU producer to normal consumer: 0 cycles.
  - ALU producer to branch: 1 cycle.
  - Load producer to normal consumer: 1 cycle.
  - Load producer to branch: 2 cycles.
- rs_addr == rt_addr is legal; it is evaluated once.
- No register is hardwired to zero; R0 is tracked like any other register.
- stall_cycles increments when stall & ~freeze, and saturates at all-ones.

## Timing
- Reset (asynchronous): all cnt = 0, busy = 0, stall = 0 (given no pending entries), stall_cycles = 0.
- Latency: an issue at edge t is visible to the decode instruction in the cycle after t.
- The counter decrements once per non-frozen edge.
- Reissuing a pending register overwrites its count. A shorter new latency is legal and wins.
- Releasing kill takes effect at the next edge; stall is 0 in the cycle after kill.
- Reset asserted mid-countdown clears everything immediately, with no clock required.

## Test plan
- ALU writes R3 (lat 0), then normal ADD reads R3 → stall=0 throughout. The same producer followed by BEQZ on R3 → stall=1 for exactly 1 cycle; busy[3] drops after 1 edge.
- LD R2 (lat 1), then ADD reading rt=R2 → stall=1 for exactly 1 cycle. JR R2 after LD R2 → stall=1 for 2 cycles; stall_cycles advances by 2.
- LD R5 issued, then freeze held 3 cycles while a dependent instruction sits in decode → cnt[5] holds at 2 and stall stays 1. After freeze drops, stall=1 for 1 more cycle; stall_cycles advances by only 1.
- Issue to R4 with lat 3 while cnt[4]=1 → cnt[4] reloads to 4. Issue with issue_valid=1 while stall=1 → no cnt change.
- kill with R1, R6 and R7 pending → busy=0 next cycle and stall=0. Async rst pulse mid-countdown → all outputs 0 before the next clk edge.
- Rebuild with REG_W=4, LAT_W=3, EARLY_PEN=2: producer lat 7 to branch → 9 stall cycles. Hold a stall for 2**PERF_W+5 cycles → stall_cycles saturates at all-ones.
